// File: rtl/mux_scan_ctrl_if.sv
// Signal bundle between the 4:1 mux scan controller and its surroundings.
// The slave modport is the controller; the master modport is the side that
// requests scans, presents the mux output and consumes the captured word.
// Optional feature macro: SCAN_PARITY_EN (adds the even-parity bit).
interface mux_scan_ctrl_if;
  logic       start;
  logic       cont;
  logic       mux_out;
  logic       s0;
  logic       s1;
  logic       busy;
  logic       done;
  logic [3:0] data;
`ifdef SCAN_PARITY_EN
  logic       parity;
`endif

  modport slave (
    input  start,
    input  cont,
    input  mux_out,
    output s0,
    output s1,
    output busy,
    output done,
`ifdef SCAN_PARITY_EN
    output parity,
`endif
    output data
  );

  modport master (
    output start,
    output cont,
    output mux_out,
    input  s0,
    input  s1,
    input  busy,
    input  done,
`ifdef SCAN_PARITY_EN
    input  parity,
`endif
    input  data
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: steps {s1,s0} through 0..3, holds each
// select for SETTLE_CYCLES, samples mux_out once per input and publishes the
// four samples as one word with a single-cycle done strobe.
// Optional feature macro: SCAN_PARITY_EN (registered even-parity of data).
module mux_scan_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input logic            clk,
  input logic            reset,
  mux_scan_ctrl_if.slave bus
);

  // A settle value of 0 is treated as 1; the counter ends at SETTLE_LAST.
  localparam int              SETTLE_EFF  = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_EFF - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Even-parity bit over the captured word.
  function automatic logic even_parity(input logic [3:0] word);
    even_parity = ^word;
  endfunction

  state_t           state_q,  state_d;
  logic [1:0]       k_q,      k_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [1:0]       sel_q,    sel_d;
  logic [3:0]       shadow_q, shadow_d;
  logic [3:0]       data_q,   data_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic             parity_q, parity_d;

  // Next-state, counter, shadow and output-register computation.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    parity_d = parity_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SETTLE;
          k_d     = 2'd0;
          cnt_d   = '0;
          sel_d   = 2'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q >= SETTLE_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_SAMPLE: begin
        shadow_d[k_q] = bus.mux_out;
        if (k_q == 2'd3) begin
          // The word is loaded on the edge entering DONE so that data and
          // parity are already valid during the done-strobe cycle.
          state_d  = ST_DONE;
          data_d   = shadow_d;
          parity_d = even_parity(shadow_d);
          sel_d    = 2'd0;
        end else begin
          state_d = ST_SETTLE;
          k_d     = k_q + 2'd1;
          sel_d   = k_q + 2'd1;
          cnt_d   = '0;
        end
      end
      ST_DONE: begin
        sel_d = 2'd0;
        k_d   = 2'd0;
        cnt_d = '0;
        if (bus.cont) begin
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        k_d     = 2'd0;
        cnt_d   = '0;
        sel_d   = 2'd0;
      end
    endcase

    // busy/done are registered, so they are derived from the next state.
    if ((state_d == ST_SETTLE) || (state_d == ST_SAMPLE)) begin
      busy_d = 1'b1;
    end else begin
      busy_d = 1'b0;
    end
    if (state_d == ST_DONE) begin
      done_d = 1'b1;
    end else begin
      done_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset; reset discards any partial scan.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      k_q      <= 2'd0;
      cnt_q    <= '0;
      sel_q    <= 2'd0;
      shadow_q <= 4'b0000;
      data_q   <= 4'b0000;
      parity_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      parity_q <= parity_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.s0   = sel_q[0];
  assign bus.s1   = sel_q[1];
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.data = data_q;
`ifdef SCAN_PARITY_EN
  assign bus.parity = parity_q;
`else
  logic unused_parity_s;
  assign unused_parity_s = parity_q;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed self-checking bench for mux_scan_ctrl with default parameters
// (SETTLE_CYCLES=2, so one scan takes 13 cycles from the start cycle).
// Optional feature macro: SCAN_PARITY_EN (adds parity checks).
module tb_mux_scan_ctrl;
  logic       clk;
  logic       reset;
  logic [3:0] in_vec;
  int         checks;
  int         errors;

  mux_scan_ctrl_if bus();

  mux_scan_ctrl #(.SETTLE_CYCLES(2), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // 4:1 mux model: input i appears when {s1,s0} = i.
  assign bus.mux_out = in_vec[{bus.s1, bus.s0}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1ns past the edge for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full scan: call with the start (or cont-from-DONE) condition set up.
  // Cycle c=1 is the first SETTLE cycle, c=13 the done cycle.
  task automatic check_scan(input string tag, input logic [3:0] exp, input bit drop_start);
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (drop_start) bus.start = 1'b0;
      if (c < 13) begin
        chk({tag, "_run"}, {4'b0, bus.done, bus.busy, bus.s1, bus.s0},
            {4'b0, 1'b0, 1'b1, 2'((c - 1) / 3)});
      end else begin
        chk({tag, "_done"}, {bus.done, bus.busy, bus.s1, bus.s0, bus.data},
            {1'b1, 1'b0, 2'b00, exp});
`ifdef SCAN_PARITY_EN
        chk({tag, "_par"}, {7'b0, bus.parity}, {7'b0, ^exp});
`endif
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.cont  = 1'b0;
    in_vec    = 4'b0000;
    tick();
    tick();
    reset = 1'b0;

    // Idle with start low: nothing happens.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_done", {7'b0, bus.done}, 8'h00);
    end
    chk("idle_state", {2'b0, bus.busy, bus.s1, bus.s0, 3'b0}, 8'h00);
    chk("idle_data", {4'b0, bus.data}, 8'h00);

    // Single pulse scan, inputs i0..i3 = 1,0,1,1.
    in_vec    = 4'b1101;
    bus.start = 1'b1;
    check_scan("pulse", 4'b1101, 1'b1);
    tick();
    chk("pulse_after", {bus.done, bus.busy, bus.s1, bus.s0, bus.data}, {4'b0000, 4'b1101});

    // Start held high: one done per scan, restart via IDLE.
    bus.start = 1'b1;
    check_scan("held1", 4'b1101, 1'b0);
    tick();
    chk("held_idle", {6'b0, bus.done, bus.busy}, 8'h00);
    check_scan("held2", 4'b1101, 1'b1);
    tick();

    // Continuous mode, inputs 0,1,1,0: back-to-back scans every 13 cycles.
    in_vec    = 4'b0110;
    bus.cont  = 1'b1;
    bus.start = 1'b1;
    check_scan("cont1", 4'b0110, 1'b1);
    check_scan("cont2", 4'b0110, 1'b0);
    bus.cont = 1'b0;
    tick();
    chk("cont_stop", {6'b0, bus.done, bus.busy}, 8'h00);

    // Reset mid-scan at T+6.
    in_vec    = 4'b1111;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset     = 1'b1;
    bus.start = 1'b1;
    tick();
    chk("rst_mid", {bus.done, bus.busy, bus.s1, bus.s0, bus.data}, 8'h00);
    reset     = 1'b0;
    bus.start = 1'b0;
    tick();
    chk("rst_idle", {bus.done, bus.busy, bus.s1, bus.s0, bus.data}, 8'h00);
    in_vec    = 4'b1101;
    bus.start = 1'b1;
    check_scan("rst_rescan", 4'b1101, 1'b1);
    tick();

    // Parity-relevant patterns: 1,1,1,0 and 1,1,0,0.
    in_vec    = 4'b0111;
    bus.start = 1'b1;
    check_scan("par_odd", 4'b0111, 1'b1);
    tick();
    in_vec    = 4'b0011;
    bus.start = 1'b1;
    check_scan("par_even", 4'b0011, 1'b1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Sequencer that sits directly upstream and downstream of the 4:1 mux stage. It drives the mux select lines {s1,s0} through inputs 0..3, waits a settle interval per input, and samples the mux output. It assembles the four samples into a 4-bit parallel word with a one-cycle done strobe. Typical use is scanning four switch/sensor lines through a single mux for the lab top level.

Parameters:
SETTLE_CYCLES, 2, cycles each select value is held before sampling; legal 1..255; 0 behaves as 1
CNT_W, 8, width of the internal settle counter; must hold SETTLE_CYCLES

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request one scan; sampled only in IDLE
cont  input  1  continuous mode; sampled in DONE
mux_out  input  1  output of the 4:1 mux being scanned
s0  output  1  mux select LSB, registered
s1  output  1  mux select MSB, registered
busy  output  1  high from first SETTLE cycle through the last SAMPLE cycle
done  output  1  one-cycle strobe; data valid and updated this cycle
data  output  4  captured word; data[k] = mux_out sampled with {s1,s0}=k
parity  output  1  present only with SCAN_PARITY_EN; see Optional Feature

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset. No asynchronous reset.
- Reset values: s0=0, s1=0, busy=0, done=0, data=4'b0000, parity=0, state=IDLE, index k=0, shadow=0.
- FSM states and transitions:
  - IDLE: outputs held. If start=1, go to SETTLE with k=0, counter=0, {s1,s0}=00.
  - SETTLE: {s1,s0}=k is held. The counter increments each cycle. When counter reaches SETTLE_CYCLES-1, go to SAMPLE.
  - SAMPLE: one cycle; shadow[k] <= mux_out.
    - If k=3, go to DONE.
    - Otherwise k <= k+1, {s1,s0} <= k+1, counter=0, go to SETTLE.
  - DONE: one cycle. data <= shadow (parity updated with it), done=1, busy=0, {s1,s0} return to 00.
    - If cont=1, go to SETTLE with k=0.
    - Otherwise go to IDLE.
- Timing: start high in IDLE at cycle T gives first SETTLE at T+1. Each input takes SETTLE_CYCLES+1 cycles. done is high at cycle T+4*(SETTLE_CYCLES+1)+1; with defaults, T+13.
- data changes only in DONE, never mid-scan. Partial results stay in shadow.
- start is ignored while busy=1 or in DONE; no queuing.
- k wraps only through DONE; no 3->0 transition occurs inside a scan.
- Reset mid-scan: next edge returns to IDLE. data is cleared, done is not asserted, and the partial shadow is discarded.
- start and reset high together: reset wins.
- cont=1 with start=0 in IDLE does not start a scan; cont is only examined in DONE.

Optional Feature:
Macro SCAN_PARITY_EN.
- Defined: output parity exists and is registered alongside data in DONE. parity = ^shadow (even-parity bit), reset 0.
- Undefined: the parity port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset then idle 10 cycles with start=0 -> s0=s1=0, busy=0, done never 1, data=0000.
- Inputs i0..i3=1,0,1,1 behind a mux model; start pulse at T -> {s1,s0} sequence 00,01,10,11 each held 3 cycles; done=1 only at T+13; data=4'b1101.
- Same setup, start held high through the scan -> exactly one done pulse per scan; second scan begins only from IDLE, first SETTLE 2 cycles after done.
- cont=1 with inputs 0,1,1,0 -> done pulses every 13 cycles; data=4'b0110; busy low only in DONE cycles.
- reset asserted at T+6 mid-scan -> next cycle busy=0, s0=s1=0, data=0000, no done; a new start yields a correct full scan.
- SCAN_PARITY_EN defined, inputs 1,1,1,0 -> data=0111, parity=1 in the done cycle; inputs 1,1,0,0 -> parity=0.
